// File: rtl/osecpu_runctl.sv
// Run controller for the OSECPU core: reset hold, free-run, counted stepping and PC breakpoints.
// Latency: a command accepted at an edge is visible the next cycle; breakpoint gating of cpu_en is same-cycle.
// Backpressure: cmd_ready is low only while the core reset sequence is in progress.
module osecpu_runctl #(
  parameter int RESET_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  input  logic [15:0] cpu_pc,
  input  logic [31:0] cpu_dr,
  input  logic [7:0]  cpu_cr,
  output logic        cpu_reset,
  output logic        cpu_en,
  output logic        halted,
  output logic        bp_hit,
  output logic        cmd_err,
  output logic [15:0] snap_pc,
  output logic [31:0] snap_dr,
  output logic [7:0]  snap_cr,
  output logic [31:0] cycle_count
);

  localparam logic [1:0] S_RSTHOLD = 2'd0;
  localparam logic [1:0] S_HALT    = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_STEP    = 2'd3;

  localparam logic [2:0] OP_RESET = 3'd1;
  localparam logic [2:0] OP_RUN   = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_HALT  = 3'd4;
  localparam logic [2:0] OP_SETBP = 3'd5;
  localparam logic [2:0] OP_CLRBP = 3'd6;
  localparam logic [2:0] OP_BAD   = 3'd7;

  // Reset hold counts down to zero, so it is loaded with one less than the hold length.
  localparam logic [15:0] RST_LOAD = 16'(RESET_CYCLES - 1);

  logic [1:0]  state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        first_run;
  logic        bp_en;
  logic [15:0] bp_pc;
  logic        cmd_fire;
  logic        bp_match;
  logic        stop;
  logic        go_run;
  logic        rst_cmd;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign rst_cmd   = cmd_fire & (cmd_op == OP_RESET);
  assign go_run    = cmd_fire & (cmd_op == OP_RUN) & (state == S_HALT);

  // The first RUN cycle is exempt so execution can resume from the breakpoint PC itself.
  assign bp_match  = (state == S_RUN) & bp_en & (cpu_pc == bp_pc) & ~first_run;

  assign cpu_reset = (state == S_RSTHOLD);
  assign cmd_ready = (state != S_RSTHOLD);
  assign halted    = (state == S_HALT);
  assign cpu_en    = (state == S_STEP) | ((state == S_RUN) & ~bp_match);

  // Next-state and shared reset-hold / step counter; stop flags a RUN/STEP -> HALT transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stop      = 1'b0;
    case (state)
      S_RSTHOLD: begin
        if (cnt == 16'd0) state_nxt = S_HALT;
        else              cnt_nxt   = cnt - 16'd1;
      end
      S_HALT: begin
        if (cmd_fire && cmd_op == OP_RUN) begin
          state_nxt = S_RUN;
        end else if (cmd_fire && cmd_op == OP_STEP && cmd_arg != 16'd0) begin
          state_nxt = S_STEP;
          cnt_nxt   = cmd_arg;
        end
      end
      S_RUN: begin
        if (bp_match || (cmd_fire && cmd_op == OP_HALT)) begin
          state_nxt = S_HALT;
          stop      = 1'b1;
        end
      end
      default: begin
        cnt_nxt = cnt - 16'd1;
        if (cnt == 16'd1 || (cmd_fire && cmd_op == OP_HALT)) begin
          state_nxt = S_HALT;
          stop      = 1'b1;
        end
      end
    endcase
    // A RESET command wins over any stop in the same cycle and never snapshots.
    if (rst_cmd) begin
      state_nxt = S_RSTHOLD;
      cnt_nxt   = RST_LOAD;
      stop      = 1'b0;
    end
  end

  // State, counter and first-RUN-cycle marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RSTHOLD;
      cnt       <= RST_LOAD;
      first_run <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      first_run <= go_run;
    end
  end

  // Breakpoint register and sticky bad-opcode flag; both survive RESET commands.
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_en   <= 1'b0;
      bp_pc   <= 16'd0;
      cmd_err <= 1'b0;
    end else begin
      if (cmd_fire && cmd_op == OP_SETBP) begin
        bp_pc <= cmd_arg;
        bp_en <= 1'b1;
      end else if (cmd_fire && cmd_op == OP_CLRBP) begin
        bp_en <= 1'b0;
      end
      if (cmd_fire && cmd_op == OP_BAD) cmd_err <= 1'b1;
    end
  end

  // Core state snapshot and stop cause; bp_hit holds the cause of the most recent stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_pc <= 16'd0;
      snap_dr <= 32'd0;
      snap_cr <= 8'd0;
      bp_hit  <= 1'b0;
    end else if (rst_cmd) begin
      bp_hit  <= 1'b0;
    end else if (stop) begin
      snap_pc <= cpu_pc;
      snap_dr <= cpu_dr;
      snap_cr <= cpu_cr;
      bp_hit  <= bp_match;
    end
  end

  // Saturating count of enabled core cycles since the last reset sequence.
  always_ff @(posedge clk) begin
    if (reset || rst_cmd) begin
      cycle_count <= 32'd0;
    end else if (cpu_en && cycle_count != 32'hFFFF_FFFF) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule

// File: doc/osecpu_runctl.md
# osecpu_runctl

Run controller for the OSECPU core: sequences CPU reset, free-run, cycle-stepping and PC breakpoint halt through a valid/ready command port. Sits between the host/debug interface and the core, driving the core's reset and clock-enable and snapshotting its PC, DR and CR whenever execution stops.

## Interface
- RESET_CYCLES, 4: cycles cpu_reset is held high per reset sequence (≥1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  3  0 NOP, 1 RESET, 2 RUN, 3 STEP, 4 HALT, 5 SETBP, 6 CLRBP, 7 reserved
- cmd_arg  in  16  STEP: cycle count; SETBP: breakpoint PC; else ignored
- cpu_pc  in  16  core program counter
- cpu_dr  in  32  core debug register
- cpu_cr  in  8  core condition register
- cpu_reset  out  1  core reset
- cpu_en  out  1  core clock enable
- halted  out  1  high in HALT state
- bp_hit  out  1  sticky: last stop caused by breakpoint
- cmd_err  out  1  sticky: op 7 received
- snap_pc / snap_dr / snap_cr  out  16/32/8  core state captured on HALT entry
- cycle_count  out  32  count of cpu_en cycles since last RESET, saturating

## Operation
- States: RSTHOLD, HALT, RUN, STEP.
- RSTHOLD: cpu_reset=1, cpu_en=0, cmd_ready=0; counter runs RESET_CYCLES cycles, then → HALT. Entered on `reset` or RESET command from any state; clears cycle_count, bp_hit; keeps breakpoint.
- HALT: cpu_en=0, halted=1. RUN → RUN; STEP with arg N>0 → STEP (load counter N); STEP with N=0 → no effect.
- RUN: cpu_en=1 except on a breakpoint-match cycle: bp_en & cpu_pc==bp_pc & not the first RUN cycle. On match: cpu_en=0 that cycle, bp_hit←1, → HALT. HALT command → HALT.
- STEP: cpu_en=1 every cycle; counter decrements; at counter==1 → HALT. Breakpoints ignored. HALT command aborts → HALT.
- SETBP: bp_pc←arg, bp_en←1. CLRBP: bp_en←0. Accepted in HALT/RUN/STEP, state unchanged.
- RUN in RUN/STEP, STEP in RUN/STEP, NOP: accepted, no effect. Op 7: accepted, cmd_err←1, no other effect.
- cmd_ready=1 in HALT, RUN, STEP; 0 in RSTHOLD.
- Snapshot: on every transition into HALT (except from RSTHOLD), snap_* ← cpu_pc/dr/cr sampled that cycle. From RSTHOLD, snap_* unchanged.
- cycle_count increments each cycle cpu_en=1; saturates at 0xFFFFFFFF.

## Timing
- Reset values: state RSTHOLD, cpu_reset=1, cpu_en=0, cmd_ready=0, halted=0, bp_hit=0, cmd_err=0, bp_en=0, bp_pc=0, snap_*=0, cycle_count=0.
- After reset deasserts: cpu_reset high exactly RESET_CYCLES cycles, then halted=1 the following cycle.
- cpu_en, cpu_reset, cmd_ready, halted are decoded from registered state; breakpoint suppression of cpu_en is combinational from cpu_pc (same-cycle).
- Command takes effect at the clock edge where valid&ready; new state visible next cycle. RUN from HALT: cpu_en high the cycle after acceptance.
- First-RUN-cycle exemption lets RUN resume from a breakpoint PC without re-hitting it.
- STEP N: exactly N cpu_en cycles, contiguous, starting the cycle after acceptance.
- Simultaneous breakpoint match and HALT command in RUN: → HALT, bp_hit←1, cpu_en=0.
- RESET command mid-RUN/STEP: cpu_en drops next cycle, RSTHOLD sequence restarts; no snapshot.
- Synchronous `reset` overrides any command in the same cycle.

## Test plan
- Reset 2 cycles → cpu_reset high 4 cycles after release, halted=1 on 5th, cmd_ready=1, cycle_count=0.
- SETBP 6, RUN with program reaching pc 6 → cpu_en=0 at pc==6, halted=1, bp_hit=1, snap_pc=6, snap_dr=0xFFFFFFFC.
- From halt at pc 6, STEP 3 → exactly 3 cpu_en cycles, cycle_count +3, halted after; STEP 0 → no cpu_en pulse.
- RUN from breakpoint PC 6 → cpu_en high first cycle, core advances past 6; HALT cmd and bp match same cycle → single halt, bp_hit=1.
- RESET command during RUN → cpu_en low next cycle, cpu_reset high 4 cycles, snap_* unchanged, bp_en retained, cycle_count=0.
- Op 7 in HALT → cmd_err=1, state HALT; CLRBP then RUN → no halt at pc 6.
